// File: rtl/data_mem_dp_if.sv
// Port bundle for data_mem_dp: port A read/masked-write, port B registered read,
// and the initialisation request/busy pair.
interface data_mem_dp_if #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 5,
  parameter int LANE_SIZE = 4
);
  localparam int NUM_LANES = DATA_SIZE / LANE_SIZE;

  logic                 INIT_REQ;
  logic                 BUSY;
  logic                 W;
  logic [NUM_LANES-1:0] WMASK;
  logic [DATA_SIZE-1:0] DATA_WR;
  logic [ADDR_SIZE-1:0] ADDR_A;
  logic [DATA_SIZE-1:0] DATA_RD_A;
  logic                 RE_B;
  logic [ADDR_SIZE-1:0] ADDR_B;
  logic [DATA_SIZE-1:0] DATA_RD_B;
  logic                 VALID_B;

  modport master (
    output INIT_REQ, W, WMASK, DATA_WR, ADDR_A, RE_B, ADDR_B,
    input  BUSY, DATA_RD_A, DATA_RD_B, VALID_B
  );

  modport slave (
    input  INIT_REQ, W, WMASK, DATA_WR, ADDR_A, RE_B, ADDR_B,
    output BUSY, DATA_RD_A, DATA_RD_B, VALID_B
  );
endinterface

// File: rtl/data_mem_dp.sv
// Dual-port data memory: async read + lane-masked write on port A, registered
// read on port B, with a sequential (re)initialisation engine sharing the write port.
module data_mem_dp #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 5,
  parameter int LANE_SIZE = 4,
  parameter int INIT_MODE = 0
) (
  input logic          clk,
  input logic          rst,
  data_mem_dp_if.slave bus
);
  localparam int NUM_LANES = DATA_SIZE / LANE_SIZE;
  localparam int MEM_SIZE  = 2 ** ADDR_SIZE;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam state_t RST_STATE = (INIT_MODE == 2) ? ST_READY : ST_INIT;

  state_t               state_reg, state_next;
  logic [ADDR_SIZE-1:0] cnt_reg, cnt_next;
  logic [DATA_SIZE-1:0] mem [MEM_SIZE];

  logic                 busy;
  logic                 collide;
  logic                 port_a_wr;
  logic                 port_b_rd;
  logic                 wr_en;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [DATA_SIZE-1:0] wr_word;
  logic [DATA_SIZE-1:0] init_word;
  logic [DATA_SIZE-1:0] word_a;
  logic [DATA_SIZE-1:0] word_b;
  logic [DATA_SIZE-1:0] merged_a;
  logic [DATA_SIZE-1:0] fwd_b;
  logic [DATA_SIZE-1:0] data_rd_b_reg;
  logic                 valid_b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RST_STATE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        if (bus.INIT_REQ) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_SIZE'(1);
          if (cnt_reg == {ADDR_SIZE{1'b1}}) state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.INIT_REQ && INIT_MODE != 2) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end
      end
      default: state_next = RST_STATE;
    endcase
  end

  assign busy      = (state_reg == ST_INIT);
  assign init_word = (INIT_MODE == 0) ? DATA_SIZE'(cnt_reg) : '0;
  assign word_a    = mem[bus.ADDR_A];
  assign word_b    = mem[bus.ADDR_B];
  assign collide   = bus.W && (bus.ADDR_A == bus.ADDR_B);

  // Port A writes are read-modify-write of the whole word; port B forwards
  // freshly written lanes on a same-address collision.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign merged_a[gi*LANE_SIZE +: LANE_SIZE] = bus.WMASK[gi]
          ? bus.DATA_WR[gi*LANE_SIZE +: LANE_SIZE]
          : word_a[gi*LANE_SIZE +: LANE_SIZE];
      assign fwd_b[gi*LANE_SIZE +: LANE_SIZE] = (collide && bus.WMASK[gi])
          ? bus.DATA_WR[gi*LANE_SIZE +: LANE_SIZE]
          : word_b[gi*LANE_SIZE +: LANE_SIZE];
    end
  endgenerate

  assign port_a_wr = bus.W && !busy && (|bus.WMASK);
  assign port_b_rd = bus.RE_B && !busy;
  assign wr_en     = busy || port_a_wr;
  assign wr_addr   = busy ? cnt_reg : bus.ADDR_A;
  assign wr_word   = busy ? init_word : merged_a;

  // Contents survive reset; only the init engine or port A change them.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_rd_b_reg <= '0;
      valid_b_reg   <= 1'b0;
    end else begin
      valid_b_reg <= port_b_rd;
      if (port_b_rd) data_rd_b_reg <= fwd_b;
    end
  end

  assign bus.BUSY      = busy;
  assign bus.DATA_RD_A = busy ? '0 : word_a;
  assign bus.DATA_RD_B = data_rd_b_reg;
  assign bus.VALID_B   = valid_b_reg;
endmodule

// File: tb/tb_data_mem_dp.sv
// Directed and randomized checks of data_mem_dp against an array-based model
// (one instance with incrementing init, one with zero init).
module tb_data_mem_dp;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [7:0] m0 [32];
  logic [7:0] m1 [32];
  logic [7:0] exp_b;

  data_mem_dp_if #(.DATA_SIZE(8), .ADDR_SIZE(5), .LANE_SIZE(4)) bus0 ();
  data_mem_dp_if #(.DATA_SIZE(8), .ADDR_SIZE(5), .LANE_SIZE(4)) bus1 ();

  data_mem_dp #(.DATA_SIZE(8), .ADDR_SIZE(5), .LANE_SIZE(4), .INIT_MODE(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  data_mem_dp #(.DATA_SIZE(8), .ADDR_SIZE(5), .LANE_SIZE(4), .INIT_MODE(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane k of the result comes from nw when mask bit k is set, else from old.
  function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] nw,
                                       input logic [1:0] mask);
    logic [7:0] r;
    r = old;
    for (int k = 0; k < 2; k++)
      if (mask[k]) r[k*4 +: 4] = nw[k*4 +: 4];
    return r;
  endfunction

  task automatic model_init();
    for (int i = 0; i < 32; i++) begin
      m0[i] = 8'(i);
      m1[i] = 8'h00;
    end
  endtask

  task automatic busy_window(input string tag);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk({tag, "_busy0"}, 32'(bus0.BUSY), 32'(k < 32));
      chk({tag, "_busy1"}, 32'(bus1.BUSY), 32'(k < 32));
      $display("%s cycle %0d busy=%0b", tag, k, bus0.BUSY);
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus0.ADDR_A = 5'(i);
      bus1.ADDR_A = 5'(i);
      #1;
      chk({tag, "_rda0"}, 32'(bus0.DATA_RD_A), 32'(m0[i]));
      chk({tag, "_rda1"}, 32'(bus1.DATA_RD_A), 32'(m1[i]));
      $display("%s addr=%0d rd0=%h rd1=%h", tag, i, bus0.DATA_RD_A, bus1.DATA_RD_A);
    end
  endtask

  initial begin
    logic [4:0] aa, ab;
    logic [7:0] d;
    logic [1:0] mk;
    logic       w, re;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus0.INIT_REQ = 0; bus0.W = 0; bus0.WMASK = 0; bus0.DATA_WR = 0;
    bus0.ADDR_A = 0; bus0.RE_B = 0; bus0.ADDR_B = 0;
    bus1.INIT_REQ = 0; bus1.W = 0; bus1.WMASK = 0; bus1.DATA_WR = 0;
    bus1.ADDR_A = 0; bus1.RE_B = 0; bus1.ADDR_B = 0;

    // Reset state
    step();
    step();
    chk("rst_busy", 32'(bus0.BUSY), 32'd1);
    chk("rst_rdb", 32'(bus0.DATA_RD_B), 32'd0);
    chk("rst_vb", 32'(bus0.VALID_B), 32'd0);
    chk("rst_rda_forced", 32'(bus0.DATA_RD_A), 32'd0);
    $display("reset: busy=%0b rdb=%h vb=%0b", bus0.BUSY, bus0.DATA_RD_B, bus0.VALID_B);

    // Reset at init cycle 10 discards progress
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("partial_busy", 32'(bus0.BUSY), 32'd1);
    end
    rst = 1'b1;
    step();
    chk("midrst_busy", 32'(bus0.BUSY), 32'd1);
    chk("midrst_vb", 32'(bus0.VALID_B), 32'd0);
    rst = 1'b0;
    busy_window("init");
    model_init();
    read_all("initread");

    // Lane-masked write at address 5, visible only after the edge
    bus0.ADDR_A = 5'd5; bus0.W = 1; bus0.WMASK = 2'b10; bus0.DATA_WR = 8'hA7;
    #1;
    chk("mask_pre_edge", 32'(bus0.DATA_RD_A), 32'(m0[5]));
    step();
    m0[5] = merge(m0[5], 8'hA7, 2'b10);
    bus0.W = 0;
    #1;
    chk("mask_write", 32'(bus0.DATA_RD_A), 32'h0000_00A5);
    chk("mask_model", 32'(bus0.DATA_RD_A), 32'(m0[5]));
    bus0.W = 1; bus0.WMASK = 2'b00; bus0.DATA_WR = 8'hFF;
    step();
    bus0.W = 0;
    #1;
    chk("mask_none", 32'(bus0.DATA_RD_A), 32'h0000_00A5);
    $display("lane mask: mem[5]=%h", bus0.DATA_RD_A);

    // Port B registered read, then hold
    bus0.RE_B = 1; bus0.ADDR_B = 5'd9;
    step();
    chk("portb_data", 32'(bus0.DATA_RD_B), 32'h09);
    chk("portb_valid", 32'(bus0.VALID_B), 32'd1);
    bus0.RE_B = 0;
    step();
    chk("portb_hold_data", 32'(bus0.DATA_RD_B), 32'h09);
    chk("portb_hold_valid", 32'(bus0.VALID_B), 32'd0);
    $display("port B: rdb=%h vb=%0b", bus0.DATA_RD_B, bus0.VALID_B);

    // Same-address collision, write-first per lane
    bus0.ADDR_A = 5'd3; bus0.ADDR_B = 5'd3; bus0.W = 1; bus0.WMASK = 2'b01;
    bus0.DATA_WR = 8'hFC; bus0.RE_B = 1;
    step();
    m0[3] = merge(m0[3], 8'hFC, 2'b01);
    chk("coll_rdb", 32'(bus0.DATA_RD_B), 32'h0C);
    chk("coll_vb", 32'(bus0.VALID_B), 32'd1);
    bus0.W = 0; bus0.RE_B = 0;
    #1;
    chk("coll_mem", 32'(bus0.DATA_RD_A), 32'h0C);
    $display("collision: rdb=%h mem[3]=%h", bus0.DATA_RD_B, bus0.DATA_RD_A);
    exp_b = 8'h0C;

    // Randomized traffic on both ports
    for (int n = 0; n < 200; n++) begin
      aa = 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, 31));
      d  = 8'($urandom);
      mk = 2'($urandom);
      w  = 1'($urandom);
      re = 1'($urandom);
      bus0.ADDR_A = aa; bus0.ADDR_B = ab; bus0.DATA_WR = d;
      bus0.WMASK = mk; bus0.W = w; bus0.RE_B = re;
      #1;
      chk("rnd_rda_pre", 32'(bus0.DATA_RD_A), 32'(m0[aa]));
      if (w) m0[aa] = merge(m0[aa], d, mk);
      if (re) exp_b = m0[ab];
      step();
      chk("rnd_rdb", 32'(bus0.DATA_RD_B), 32'(exp_b));
      chk("rnd_vb", 32'(bus0.VALID_B), 32'(re));
      chk("rnd_rda_post", 32'(bus0.DATA_RD_A), 32'(m0[aa]));
      $display("rnd %0d: w=%0b a=%0d m=%b d=%h re=%0b b=%0d rdb=%h", n, w, aa, mk, d, re, ab,
               bus0.DATA_RD_B);
    end
    bus0.W = 0; bus0.RE_B = 0;

    // Run-time re-initialisation; port traffic during it is ignored
    bus0.ADDR_A = 5'd7; bus0.W = 1; bus0.WMASK = 2'b11; bus0.DATA_WR = 8'hEE;
    step();
    m0[7] = 8'hEE;
    bus0.W = 0;
    #1;
    chk("reinit_pre_write", 32'(bus0.DATA_RD_A), 32'hEE);
    bus0.INIT_REQ = 1;
    step();
    bus0.INIT_REQ = 0;
    chk("reinit_busy_n", 32'(bus0.BUSY), 32'd1);
    chk("reinit_rda_forced", 32'(bus0.DATA_RD_A), 32'd0);
    bus0.W = 1; bus0.WMASK = 2'b11; bus0.DATA_WR = 8'h55; bus0.RE_B = 1; bus0.ADDR_B = 5'd7;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("reinit_busy", 32'(bus0.BUSY), 32'(k < 32));
      chk("reinit_vb", 32'(bus0.VALID_B), 32'd0);
      chk("reinit_rdb_hold", 32'(bus0.DATA_RD_B), 32'(exp_b));
      $display("reinit cycle %0d busy=%0b", k, bus0.BUSY);
    end
    bus0.W = 0; bus0.RE_B = 0;
    for (int i = 0; i < 32; i++) m0[i] = 8'(i);
    read_all("reinitread");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_mem_dp.md
# data_mem_dp

Parametrised dual-port data memory, the successor to the single-port data store in the datapath. Port A gives the core an asynchronous read and a lane-masked synchronous write. Port B is a registered read-only port for a second consumer, such as a debug or DMA reader. A sequential initialisation engine replaces the old single-cycle all-entry reset, so the block scales to deep memories and can be re-initialised at run time.

## Interface
- DATA_SIZE, 8: data word width; must be a multiple of LANE_SIZE
- ADDR_SIZE, 5: address width; MEM_SIZE = 2**ADDR_SIZE
- LANE_SIZE, 4: write-mask granularity in bits; NUM_LANES = DATA_SIZE/LANE_SIZE
- INIT_MODE, 0: 0 = entry i gets i (truncated/zero-extended to DATA_SIZE), 1 = all zero, 2 = no initialisation
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- INIT_REQ  in  1  request run-time re-initialisation, single-cycle pulse
- BUSY  out  1  initialisation in progress; reset value 1
- W  in  1  port A write enable
- WMASK  in  NUM_LANES  port A lane enables; bit k covers bits [k*LANE_SIZE +: LANE_SIZE]
- DATA_WR  in  DATA_SIZE  port A write data
- ADDR_A  in  ADDR_SIZE  port A address
- DATA_RD_A  out  DATA_SIZE  port A asynchronous read data
- RE_B  in  1  port B read enable
- ADDR_B  in  ADDR_SIZE  port B address
- DATA_RD_B  out  DATA_SIZE  port B registered read data; reset value 0
- VALID_B  out  1  DATA_RD_B updated this cycle; reset value 0

## Operation
- FSM has two states: INIT and READY.
- rst sampled high:
  - state becomes INIT (or READY if INIT_MODE=2), init counter becomes 0.
  - BUSY=1 (BUSY=0 if INIT_MODE=2); DATA_RD_B=0, VALID_B=0.
  - Memory contents are not modified.
- INIT, each edge with rst low:
  - mem[cnt] is written with the pattern value, then cnt increments.
  - On the edge that writes mem[MEM_SIZE-1], the state becomes READY and BUSY drops.
- INIT_REQ in READY: enter INIT with cnt=0 at the next edge; ignored if INIT_MODE=2.
- INIT_REQ in INIT: restart with cnt=0.
- rst has priority over INIT_REQ, W and RE_B.
- While BUSY=1:
  - W and RE_B are ignored; VALID_B=0; DATA_RD_B holds its value.
  - DATA_RD_A is forced to 0.
- Port A write: when W=1 and BUSY=0, only lanes with WMASK=1 of mem[ADDR_A] are updated at the edge. W=1 with WMASK=0 has no effect.
- Port A read: when BUSY=0, DATA_RD_A = mem[ADDR_A] combinationally. It reflects a write at ADDR_A after the writing edge, not before.
- Port B read: RE_B=1 with BUSY=0 at an edge loads DATA_RD_B with mem[ADDR_B] and sets VALID_B=1 for one cycle. With RE_B=0, VALID_B=0 and DATA_RD_B holds.
- Collision (same edge, W=1, RE_B=1, ADDR_A=ADDR_B) is write-first, per lane:
  - masked lanes return DATA_WR;
  - unmasked lanes return the old content.
- Address wrap: none needed; the full ADDR_SIZE range is valid memory.

## Timing
- Initialisation latency: BUSY is high for exactly MEM_SIZE cycles after the last rst-high edge, i.e. 32 cycles at defaults.
- Re-initialisation: INIT_REQ at edge N sets BUSY=1 after edge N; BUSY=0 after edge N+MEM_SIZE.
- Write: 1 edge. Port A read: 0 cycles (combinational).
- Port B read: 1 cycle, RE_B at edge N gives data and VALID_B after edge N.
- Back-to-back port B reads are sustained at 1 per cycle.
- rst mid-INIT discards progress; the count restarts at the first rst-low edge.
- Entries that were written by neither initialisation nor port A hold undefined data. This case occurs only with INIT_MODE=2.

## Test plan
- Defaults, rst high 2 cycles then low:
  - BUSY=1 for 32 cycles, then 0;
  - port A read of addresses 0..31 returns 0x00..0x1F;
  - DATA_RD_B=0 and VALID_B=0 during reset.
- Lane mask: mem[5]=0x05; write with W=1, WMASK=2'b10, DATA_WR=0xA7:
  - DATA_RD_A at ADDR_A=5 reads 0xA5;
  - a write with WMASK=2'b00 leaves 0xA5.
- Port B: RE_B=1, ADDR_B=9 at edge N gives DATA_RD_B=0x09 and VALID_B=1 after N. RE_B=0 at N+1 gives VALID_B=0 with DATA_RD_B still 0x09.
- Collision: mem[3]=0x03; same edge W=1, WMASK=2'b01, DATA_WR=0xFC, ADDR_A=ADDR_B=3, RE_B=1:
  - DATA_RD_B=0x0C;
  - mem[3]=0x0C afterwards.
- Run-time re-init: write mem[7]=0xEE, pulse INIT_REQ. BUSY is high 32 cycles; W=1 during that time is ignored; afterwards mem[7]=0x07.
- Reset mid-INIT: assert rst at init cycle 10; BUSY stays high a full 32 cycles from release. With INIT_MODE=1 all entries read 0x00.
